sha3_msg_feeder: RTL and testbench
==================================

Name: sha3_msg_feeder

Overview:
Host-side companion to sha3_low_throughput. It accepts a byte-serial message stream, packs bytes into 32-bit big-endian words and drives the core's in/in_ready/is_last/byte_num inputs, honouring buffer_full. It captures the 512-bit digest on out_ready and returns it as sixteen 32-bit words over a valid/ready stream. It then pulses the core reset so the core is ready for the next message.

Parameters:
DIGEST_WORDS, 16, number of 32-bit digest words drained per message (512/32).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
s_data  in  8  message byte.
s_valid  in  1  s_data valid.
s_last  in  1  final byte of message; qualified by s_valid.
s_ready  out  1  feeder accepts a byte this cycle.
core_reset  out  1  active-high reset to sha3_low_throughput.
core_in  out  32  packed word to core.
core_in_ready  out  1  core_in valid.
core_is_last  out  1  final word of message.
core_byte_num  out  2  valid bytes in the final word (0-3).
core_buffer_full  in  1  core cannot accept a word.
core_out  in  512  core digest.
core_out_ready  in  1  digest valid; held high until core reset.
d_data  out  32  digest word.
d_valid  out  1  d_data valid.
d_ready  in  1  downstream accepts d_data.
d_last  out  1  marks the final digest word.

Behaviour:
- Reset (reset==0 at a clock edge) puts the FSM in CORE_RST. Reset values: s_ready=0, core_reset=1, core_in=0, core_in_ready=0, core_is_last=0, core_byte_num=0, d_valid=0, d_last=0, d_data=0, byte count=0, digest index=0.
- States: CORE_RST, PACK, SEND, SEND_PAD, WAIT_HASH, DRAIN.
- CORE_RST: core_reset=1 for exactly one cycle, then go to PACK. After reset is released, s_ready rises on the next cycle.
- PACK: s_ready=1. A byte transfers when s_valid&&s_ready. Byte k of the word (k=0..3) goes to core_in[31-8k -: 8]; unfilled bytes are 0.
  - 4th byte accepted and s_last=0: go to SEND with is_last=0.
  - s_last accepted with total count c<4: go to SEND with is_last=1 and byte_num=c.
  - s_last accepted with c==4: go to SEND with is_last=0, then SEND_PAD.
- SEND / SEND_PAD: core_in_ready=1. A word transfers in a cycle where core_in_ready=1 and core_buffer_full=0. Until that transfer, core_in, core_is_last and core_byte_num are held stable and s_ready=0.
  - SEND_PAD presents core_in=0, is_last=1, byte_num=0.
  - After the transfer: if the word was last, go to WAIT_HASH. Else if a pad is owed, go to SEND_PAD. Otherwise clear the word and byte count and return to PACK.
- WAIT_HASH: all handshakes idle. On the first cycle with core_out_ready=1, register core_out and go to DRAIN (index=0). There is no timeout.
- DRAIN: d_valid=1 and d_data = digest[511-32*i -: 32], so word 0 is the MS word.
  - Index advances on d_valid&&d_ready.
  - d_last=1 when i==DIGEST_WORDS-1.
  - The transfer of the last word goes to CORE_RST.
  - d_data/d_valid stay stable while d_ready=0.
- s_ready=0 in every state except PACK; no overlap with the next message.
- Zero-length messages are not supported: s_last always accompanies a byte.
- Reset asserted in any state aborts the operation immediately on that edge: the partial word and digest are discarded and outputs take their reset values.
- core_buffer_full is ignored outside SEND/SEND_PAD. core_out_ready is ignored outside WAIT_HASH.

Decomposition:
- sha3_feeder_pkg holds:
  - the state enum (CORE_RST, PACK, SEND, SEND_PAD, WAIT_HASH, DRAIN);
  - WORD_W=32;
  - DIGEST_W=512;
  - BYTE_NUM_W=2.
- One sub-module, sha3_digest_serializer, is natural. It holds the 512-bit capture register, the 4-bit index and the d_valid/d_ready/d_last logic, with capture and done strobes to the top FSM.
- Packing and the FSM live in the top module.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), buffer_full=0 -> one core word 0x61626300, is_last=1, byte_num=3; then WAIT_HASH.
- "abcd" -> word 0x61626364 with is_last=0, next cycle word 0x00000000 with is_last=1, byte_num=0.
- 9-byte message 0x01..0x09 -> words 0x01020304 and 0x05060708 with is_last=0, then 0x09000000 with is_last=1, byte_num=1.
- core_buffer_full=1 for 5 cycles while a word is pending -> core_in_ready and core_in held stable, exactly one transfer after buffer_full falls, s_ready=0 throughout.
- core_out=512'h{16 words 0x00000000..0x0000000F from MS to LS} with out_ready=1, and d_ready toggling 1/0 -> d_data sequence 0x0,0x1,...,0xF with no duplicates or drops. d_last=1 only on 0xF. Then core_reset=1 for one cycle, then s_ready=1.
- reset=0 for one cycle mid-DRAIN at word 5 -> d_valid=0 next cycle and core_reset=1 for the reset cycle plus one. A new "abc" message then yields 0x61626300 correctly.

Source files
------------

// File: rtl/sha3_feeder_pkg.sv
// Shared types and widths for the SHA-3 message feeder and its digest serializer.
package sha3_feeder_pkg;

  localparam int WORD_W     = 32;
  localparam int DIGEST_W   = 512;
  localparam int BYTE_NUM_W = 2;

  typedef enum logic [2:0] {
    CORE_RST,
    PACK,
    SEND,
    SEND_PAD,
    WAIT_HASH,
    DRAIN
  } state_e;

  // Drops byte b into lane k of a big-endian word (lane 0 is the MS byte).
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                   input logic [7:0]        b,
                                                   input logic [1:0]        k);
    logic [WORD_W-1:0] w;
    w = word;
    case (k)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha3_digest_serializer.sv
// Captures the 512-bit core digest and streams it out MS word first over valid/ready.
module sha3_digest_serializer
  import sha3_feeder_pkg::*;
#(
  parameter int DIGEST_WORDS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_capture,
  input  logic [DIGEST_W-1:0] i_digest,
  output logic                o_done,
  output logic [WORD_W-1:0]   o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last
);

  localparam int IDX_W = $clog2(DIGEST_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGEST_WORDS - 1);

  logic [DIGEST_W-1:0] r_digest;
  logic [IDX_W-1:0]    r_idx;
  logic                r_active;
  logic [WORD_W-1:0]   w_word;
  logic                w_last;

  // NOTE: r_digest is pure data with no reset; o_data is gated by r_active so
  // stale contents never reach the port.
  always_ff @(posedge clk) begin
    if (i_capture) r_digest <= i_digest;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx    <= '0;
      r_active <= 1'b0;
    end else if (i_capture) begin
      r_idx    <= '0;
      r_active <= 1'b1;
    end else if (r_active && i_ready) begin
      r_active <= (r_idx != LAST_IDX);
      r_idx    <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // NOTE: default assignment first keeps this mux free of latches.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < DIGEST_WORDS; i++) begin
      if (r_idx == IDX_W'(i)) w_word = r_digest[DIGEST_W-1-WORD_W*i -: WORD_W];
    end
  end

  assign w_last  = r_active && (r_idx == LAST_IDX);
  assign o_valid = r_active;
  assign o_last  = w_last;
  assign o_data  = r_active ? w_word : '0;
  assign o_done  = w_last && i_ready;

endmodule

// File: rtl/sha3_msg_feeder.sv
// Byte-serial to 32-bit word packer feeding sha3_low_throughput, plus digest readback
// and a one-cycle core reset between messages.
module sha3_msg_feeder
  import sha3_feeder_pkg::*;
#(
  parameter int DIGEST_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  core_reset,
  output logic [WORD_W-1:0]     core_in,
  output logic                  core_in_ready,
  output logic                  core_is_last,
  output logic [BYTE_NUM_W-1:0] core_byte_num,
  input  logic                  core_buffer_full,
  input  logic [DIGEST_W-1:0]   core_out,
  input  logic                  core_out_ready,
  output logic [WORD_W-1:0]     d_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic                  d_last
);

  state_e                r_state, w_next;
  logic [WORD_W-1:0]     r_word;
  logic [2:0]            r_count;
  logic                  r_is_last;
  logic                  r_pad_owed;
  logic [BYTE_NUM_W-1:0] r_byte_num;
  logic [2:0]            w_count_nxt;
  logic                  w_capture;
  logic                  w_done;

  assign w_count_nxt = r_count + 3'd1;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= CORE_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    s_ready       = 1'b0;
    core_reset    = 1'b0;
    core_in_ready = 1'b0;
    w_capture     = 1'b0;
    unique case (r_state)
      CORE_RST: begin
        core_reset = 1'b1;
        w_next     = PACK;
      end
      PACK: begin
        s_ready = 1'b1;
        if (s_valid && (s_last || w_count_nxt == 3'd4)) w_next = SEND;
      end
      SEND: begin
        core_in_ready = 1'b1;
        if (!core_buffer_full)
          w_next = r_is_last ? WAIT_HASH : (r_pad_owed ? SEND_PAD : PACK);
      end
      SEND_PAD: begin
        core_in_ready = 1'b1;
        if (!core_buffer_full) w_next = WAIT_HASH;
      end
      WAIT_HASH: begin
        if (core_out_ready) begin
          w_capture = 1'b1;
          w_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (w_done) w_next = CORE_RST;
      end
      default: w_next = CORE_RST;
    endcase
  end

  // Word assembly; CORE_RST also wipes it so each message starts clean.
  always_ff @(posedge clk) begin
    if (!reset || r_state == CORE_RST) begin
      r_word     <= '0;
      r_count    <= '0;
      r_is_last  <= 1'b0;
      r_pad_owed <= 1'b0;
      r_byte_num <= '0;
    end else begin
      case (r_state)
        PACK: begin
          if (s_valid) begin
            r_word  <= place_byte(r_word, s_data, r_count[1:0]);
            r_count <= w_count_nxt;
            if (s_last) begin
              r_is_last  <= (w_count_nxt != 3'd4);
              r_pad_owed <= (w_count_nxt == 3'd4);
              r_byte_num <= w_count_nxt[1:0];
            end
          end
        end
        SEND: begin
          if (!core_buffer_full) begin
            if (r_pad_owed) begin
              r_word     <= '0;
              r_is_last  <= 1'b1;
              r_byte_num <= '0;
              r_pad_owed <= 1'b0;
            end else if (!r_is_last) begin
              r_word  <= '0;
              r_count <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign core_in       = core_in_ready ? r_word : '0;
  assign core_is_last  = core_in_ready && r_is_last;
  assign core_byte_num = core_in_ready ? r_byte_num : '0;

  sha3_digest_serializer #(
    .DIGEST_WORDS(DIGEST_WORDS)
  ) u_serializer (
    .clk      (clk),
    .reset    (reset),
    .i_capture(w_capture),
    .i_digest (core_out),
    .o_done   (w_done),
    .o_data   (d_data),
    .o_valid  (d_valid),
    .i_ready  (d_ready),
    .o_last   (d_last)
  );

endmodule

// File: tb/tb_sha3_msg_feeder.sv
// Randomized scenario bench for sha3_msg_feeder against a queue-based word/digest model.
module tb_sha3_msg_feeder;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] word;
    logic        last;
    logic [1:0]  bn;
    int          cyc;
  } cw_t;
  typedef struct {
    logic [31:0] data;
    logic        last;
  } dw_t;
  typedef logic [31:0] dig_words_t[16];

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic         core_reset;
  logic [31:0]  core_in;
  logic         core_in_ready;
  logic         core_is_last;
  logic [1:0]   core_byte_num;
  logic         core_buffer_full = 1'b0;
  logic [511:0] core_out = '0;
  logic         core_out_ready = 1'b0;
  logic [31:0]  d_data;
  logic         d_valid;
  logic         d_ready = 1'b0;
  logic         d_last;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hold_viol = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  cw_t obs_w[$];
  dw_t obs_d[$];

  sha3_msg_feeder #(.DIGEST_WORDS(16)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out), .core_out_ready(core_out_ready),
    .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready), .d_last(d_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (core_in_ready && !core_buffer_full)
      obs_w.push_back('{word: core_in, last: core_is_last, bn: core_byte_num, cyc: cyc});
    if (d_valid && d_ready)
      obs_d.push_back('{data: d_data, last: d_last});
    if (prev_hold && d_valid && d_data !== prev_data) hold_viol <= hold_viol + 1;
    prev_hold <= d_valid && !d_ready;
    prev_data <= d_data;
  end

  // Expected core words straight from the packing rules.
  function automatic void model_words(input byte_q_t msg, output cw_t exp[$]);
    int n, nw, rem;
    logic [31:0] v;
    exp = {};
    n   = msg.size();
    nw  = (n + 3) / 4;
    rem = n % 4;
    for (int w = 0; w < nw; w++) begin
      v = '0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) v = v | (32'(msg[4*w+b]) << (24 - 8 * b));
      exp.push_back('{word: v, last: (w == nw - 1) && (rem != 0),
                      bn: (w == nw - 1) ? 2'(rem) : 2'd0, cyc: 0});
    end
    if (rem == 0) exp.push_back('{word: 32'h0, last: 1'b1, bn: 2'd0, cyc: 0});
  endfunction

  // bf_mode: 0 buffer never full, 1 random, 2 held full until word pending 5 cycles.
  task automatic feed(input byte_q_t msg, input int bf_mode);
    int i = 0;
    int guard = 0;
    logic acc;
    while (i < msg.size() && guard < 2000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = msg[i];
      s_last  = (i == msg.size() - 1);
      if (bf_mode == 1) core_buffer_full = ($urandom_range(0, 2) == 0);
      else              core_buffer_full = (bf_mode == 2);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d bytes, required %0d", i, msg.size());
    end
  endtask

  task automatic run_message(input string name, input byte_q_t msg, input int bf_mode);
    cw_t exp[$];
    int base, guard;
    model_words(msg, exp);
    base = obs_w.size();
    feed(msg, bf_mode);
    if (bf_mode == 2) begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if ({core_in_ready, s_ready, core_in, core_is_last} !== {1'b1, 1'b0, exp[0].word, exp[0].last}) begin
          errors++;
          $display("FAIL %s_hold: rdy=%b s_ready=%b in=%h last=%b, required 1 0 %h %b",
                   name, core_in_ready, s_ready, core_in, core_is_last, exp[0].word, exp[0].last);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (obs_w.size() - base !== 0) begin
        errors++;
        $display("FAIL %s_no_xfer_while_full: got %0d transfers, required 0", name, obs_w.size() - base);
      end
    end
    guard = 0;
    while (obs_w.size() - base < exp.size() && guard < 300) begin
      core_buffer_full = (bf_mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    core_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_w.size() - base !== exp.size()) begin
      errors++;
      $display("FAIL %s_word_count: got %0d, required %0d", name, obs_w.size() - base, exp.size());
    end
    for (int k = 0; k < exp.size() && base + k < obs_w.size(); k++) begin
      checks++;
      if ({obs_w[base+k].word, obs_w[base+k].last, obs_w[base+k].bn} !==
          {exp[k].word, exp[k].last, exp[k].bn}) begin
        errors++;
        $display("FAIL %s_word%0d: got %h last=%b bn=%0d, required %h last=%b bn=%0d", name, k,
                 obs_w[base+k].word, obs_w[base+k].last, obs_w[base+k].bn,
                 exp[k].word, exp[k].last, exp[k].bn);
      end
    end
    checks++;
    if (s_ready !== 1'b0 || core_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_wait_hash_idle: s_ready=%b core_in_ready=%b, required 0 0", name, s_ready, core_in_ready);
    end
  endtask

  // rd_mode: 0 toggling 1/0, 1 random, 2 always ready. stop_at < 16 leaves DRAIN mid-way.
  task automatic run_digest(input string name, input dig_words_t w, input int rd_mode, input int stop_at);
    logic [511:0] dig = '0;
    int base, guard, got;
    logic tog = 1'b1;
    for (int i = 0; i < 16; i++) dig = (dig << 32) | 512'(w[i]);
    core_out       = dig;
    core_out_ready = 1'b1;
    base  = obs_d.size();
    guard = 0;
    while (obs_d.size() - base < stop_at && guard < 600) begin
      d_ready = (rd_mode == 0) ? tog : (rd_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      tog = ~tog;
      @(posedge clk); #1;
      guard++;
    end
    d_ready = 1'b0;
    got = obs_d.size() - base;
    checks++;
    if (got !== stop_at) begin
      errors++;
      $display("FAIL %s_digest_count: got %0d words, required %0d", name, got, stop_at);
    end
    for (int i = 0; i < got && i < stop_at; i++) begin
      checks++;
      if ({obs_d[base+i].data, obs_d[base+i].last} !== {w[i], 1'(i == 15)}) begin
        errors++;
        $display("FAIL %s_digest%0d: got %h last=%b, required %h last=%b", name, i,
                 obs_d[base+i].data, obs_d[base+i].last, w[i], i == 15);
      end
    end
    if (stop_at == 16) begin
      checks++;
      if ({core_reset, d_valid, s_ready} !== 3'b100) begin
        errors++;
        $display("FAIL %s_core_reset_pulse: core_reset,d_valid,s_ready=%b, required 100", name, {core_reset, d_valid, s_ready});
      end
      core_out_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({core_reset, s_ready} !== 2'b01) begin
        errors++;
        $display("FAIL %s_back_to_pack: core_reset,s_ready=%b, required 01", name, {core_reset, s_ready});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, core_reset, core_in_ready, core_is_last, core_byte_num, d_valid, d_last} !== 8'b0100_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 01000000",
               {s_ready, core_reset, core_in_ready, core_is_last, core_byte_num, d_valid, d_last});
    end
    checks++;
    if ({core_in, d_data} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: core_in=%h d_data=%h, required 0 0", core_in, d_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s_ready, core_reset} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: s_ready,core_reset=%b, required 10", {s_ready, core_reset});
    end
  endtask

  task automatic test_abc_and_drain();
    byte_q_t m;
    dig_words_t w;
    m = {8'h61, 8'h62, 8'h63};
    run_message("abc", m, 0);
    for (int i = 0; i < 16; i++) w[i] = 32'(i);
    run_digest("drain_toggle", w, 0, 16);
  endtask

  task automatic test_abcd_pad();
    byte_q_t m;
    dig_words_t w;
    int base;
    m = {8'h61, 8'h62, 8'h63, 8'h64};
    base = obs_w.size();
    run_message("abcd", m, 0);
    checks++;
    if (obs_w.size() >= base + 2 && obs_w[base+1].cyc - obs_w[base].cyc !== 1) begin
      errors++;
      $display("FAIL abcd_pad_next_cycle: gap %0d cycles, required 1", obs_w[base+1].cyc - obs_w[base].cyc);
    end
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    run_digest("abcd_digest", w, 1, 16);
  endtask

  task automatic test_nine_bytes();
    byte_q_t m;
    dig_words_t w;
    m = {};
    for (int i = 1; i <= 9; i++) m.push_back(8'(i));
    run_message("nine", m, 0);
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    run_digest("nine_digest", w, 2, 16);
  endtask

  task automatic test_buffer_full();
    byte_q_t m;
    dig_words_t w;
    m = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
    run_message("bfull", m, 2);
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    run_digest("bfull_digest", w, 1, 16);
  endtask

  task automatic test_random_msgs();
    byte_q_t m;
    dig_words_t w;
    for (int t = 0; t < 6; t++) begin
      m = {};
      for (int i = 0, n = $urandom_range(1, 13); i < n; i++) m.push_back(8'($urandom));
      run_message($sformatf("rand%0d", t), m, 1);
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      run_digest($sformatf("rand%0d_digest", t), w, 1, 16);
    end
  endtask

  task automatic test_reset_mid_drain();
    byte_q_t m;
    dig_words_t w;
    m = {8'h61, 8'h62, 8'h63};
    run_message("pre_abort", m, 0);
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    run_digest("abort_drain", w, 2, 5);
    checks++;
    if ({d_valid, d_data} !== {1'b1, w[5]}) begin
      errors++;
      $display("FAIL abort_at_word5: d_valid=%b d_data=%h, required 1 %h", d_valid, d_data, w[5]);
    end
    reset = 1'b0;
    core_out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({d_valid, d_last, core_reset, s_ready, d_data} !== {4'b0010, 32'h0}) begin
      errors++;
      $display("FAIL abort_reset_state: d_valid,d_last,core_reset,s_ready=%b d_data=%h, required 0010 0",
               {d_valid, d_last, core_reset, s_ready}, d_data);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({core_reset, s_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_release: core_reset,s_ready=%b, required 01", {core_reset, s_ready});
    end
    run_message("post_abort_abc", m, 0);
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    run_digest("post_abort_digest", w, 0, 16);
  endtask

  initial begin
    test_reset();
    test_abc_and_drain();
    test_abcd_pad();
    test_nine_bytes();
    test_buffer_full();
    test_random_msgs();
    test_reset_mid_drain();
    checks++;
    if (hold_viol !== 0) begin
      errors++;
      $display("FAIL d_data_stable_while_stalled: %0d changes, required 0", hold_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
